// File: rtl/truth_table_scanner.sv
// Walks {A,B,C} through all eight minterms, waits SETTLE_CYCLES per minterm and captures F_IN into TABLE.
// Optional expected-table comparison is enabled by defining TRUTH_TABLE_SCANNER_COMPARE_EN.
module truth_table_scanner #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       F_IN,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] TABLE
`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    ,
    input  logic [7:0] EXPECT,
    output logic       MATCH
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    localparam logic [3:0] LP_LAST_COUNT = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_index;
    logic [3:0] r_count;
    logic [2:0] r_abc;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_table;

    state_t     w_state_next;
    logic [2:0] w_index_next;
    logic [3:0] w_count_next;
    logic [2:0] w_abc_next;
    logic       w_busy_next;
    logic       w_done_next;
    logic [7:0] w_table_next;
    logic       w_accept;

    // FINISH also accepts START so a held request restarts without an idle cycle.
    always_comb begin
        w_state_next = r_state;
        w_index_next = r_index;
        w_count_next = r_count;
        w_table_next = r_table;
        w_accept     = 1'b0;

        case (r_state)
            IDLE: begin
                if (START) begin
                    w_accept = 1'b1;
                end
            end
            SETTLE: begin
                w_count_next = r_count + 4'd1;
                if (r_count == LP_LAST_COUNT) begin
                    w_state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                w_table_next[r_index] = F_IN;
                if (r_index == 3'd7) begin
                    w_state_next = FINISH;
                end else begin
                    w_index_next = r_index + 3'd1;
                    w_count_next = 4'd0;
                    w_state_next = SETTLE;
                end
            end
            FINISH: begin
                w_state_next = IDLE;
                if (START) begin
                    w_accept = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_accept) begin
            w_state_next = SETTLE;
            w_index_next = 3'd0;
            w_count_next = 4'd0;
            w_table_next = 8'h00;
        end

        w_busy_next = (w_state_next == SETTLE) || (w_state_next == SAMPLE);
        w_done_next = (w_state_next == FINISH);
        w_abc_next  = w_busy_next ? w_index_next : 3'd0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_index <= 3'd0;
            r_count <= 4'd0;
            r_abc   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            r_count <= w_count_next;
            r_abc   <= w_abc_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_table <= w_table_next;
        end
    end

    assign A     = r_abc[2];
    assign B     = r_abc[1];
    assign C     = r_abc[0];
    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign TABLE = r_table;

`ifdef TRUTH_TABLE_SCANNER_COMPARE_EN
    logic [7:0] r_expect;
    logic       r_match;

    // The verdict is computed from the table value being written on the final sample edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_expect <= 8'h00;
            r_match  <= 1'b0;
        end else if (w_accept) begin
            r_expect <= EXPECT;
            r_match  <= 1'b0;
        end else if (w_done_next) begin
            r_match  <= (w_table_next == r_expect);
        end
    end

    assign MATCH = r_match;
`endif

endmodule
